// File: rtl/expr_eval_if.sv
// expr_eval_if -- character stream in, result pulse out.
//   in_valid/in : one ASCII character per cycle when in_valid is high
//   res_valid   : one-cycle pulse, result/err valid
//   result/err  : value of the completed expression / syntax-error flag
//   busy        : an expression is partially received
interface expr_eval_if;
  logic        in_valid;
  logic [7:0]  in;
  logic        res_valid;
  logic [15:0] result;
  logic        err;
  logic        busy;

  modport slave  (input in_valid, in, output res_valid, result, err, busy);
  modport master (output in_valid, in, input res_valid, result, err, busy);
endinterface

// File: rtl/expr_eval.sv
// expr_eval -- streaming evaluator for "digit (op digit)* =" expressions,
// single-digit operands, '*' binds tighter than '+', all arithmetic mod 2^16.
// Ports:
//   clk   : clock, rising edge
//   clr_n : asynchronous active-low reset
//   bus   : expr_eval_if.slave (in_valid, in, res_valid, result, err, busy)
// Optional feature: define EXPR_EVAL_SUB_EN to accept '-' as an additive
// operator; the pending term then carries a 1-bit sign.
module expr_eval (
  input  logic        clk,
  input  logic        clr_n,
  expr_eval_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, OPND, OPER, ERR} state_t;

  state_t      state_q, state_d;
  logic [15:0] sum_q, sum_d;
  logic [15:0] term_q, term_d;
  logic        mul_q, mul_d;      // last operator was '*'
  logic [15:0] result_q, result_d;
  logic        err_q, err_d;
  logic        res_vld_q, res_vld_d;
`ifdef EXPR_EVAL_SUB_EN
  logic        sign_q, sign_d;    // pending term is subtracted
`endif

  // token decode
  logic        is_dig, is_add, is_mul, is_eq, is_sub;
  logic [3:0]  dig;
  logic [15:0] dig16, prod, acc;

  assign is_dig = (bus.in >= 8'd48) && (bus.in <= 8'd57);
  assign is_add = (bus.in == 8'd43);
  assign is_mul = (bus.in == 8'd42);
  assign is_eq  = (bus.in == 8'd61);
`ifdef EXPR_EVAL_SUB_EN
  assign is_sub = (bus.in == 8'd45);
`else
  assign is_sub = 1'b0;
`endif
  assign dig    = bus.in[3:0];    // '0'..'9' are 0x30..0x39
  assign dig16  = {12'd0, dig};
  assign prod   = term_q * dig16;

  // sum with the pending term folded in
`ifdef EXPR_EVAL_SUB_EN
  assign acc = sign_q ? (sum_q - term_q) : (sum_q + term_q);
`else
  assign acc = sum_q + term_q;
`endif

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    term_d    = term_q;
    mul_d     = mul_q;
    result_d  = result_q;
    err_d     = err_q;
    res_vld_d = 1'b0;
`ifdef EXPR_EVAL_SUB_EN
    sign_d    = sign_q;
`endif
    if (bus.in_valid) begin
      if (is_eq) begin
        // every '=' ends the expression and restarts from a clean slate
        state_d   = IDLE;
        sum_d     = '0;
        term_d    = '0;
        mul_d     = 1'b0;
        res_vld_d = 1'b1;
`ifdef EXPR_EVAL_SUB_EN
        sign_d    = 1'b0;
`endif
        if (state_q == OPND) begin
          result_d = acc;
          err_d    = 1'b0;
        end else begin
          result_d = '0;
          err_d    = 1'b1;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (is_dig) begin
              state_d = OPND;
              term_d  = dig16;
            end else begin
              state_d = ERR;
            end
          end
          OPND: begin
            if (is_mul) begin
              state_d = OPER;
              mul_d   = 1'b1;
            end else if (is_add || is_sub) begin
              state_d = OPER;
              sum_d   = acc;
              mul_d   = 1'b0;
`ifdef EXPR_EVAL_SUB_EN
              sign_d  = is_sub;
`endif
            end else begin
              state_d = ERR;
            end
          end
          OPER: begin
            if (is_dig) begin
              state_d = OPND;
              term_d  = mul_q ? prod : dig16;
            end else begin
              state_d = ERR;
            end
          end
          default: state_d = ERR;  // ERR absorbs everything but '='
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= IDLE;
      sum_q     <= '0;
      term_q    <= '0;
      mul_q     <= 1'b0;
      result_q  <= '0;
      err_q     <= 1'b0;
      res_vld_q <= 1'b0;
`ifdef EXPR_EVAL_SUB_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      term_q    <= term_d;
      mul_q     <= mul_d;
      result_q  <= result_d;
      err_q     <= err_d;
      res_vld_q <= res_vld_d;
`ifdef EXPR_EVAL_SUB_EN
      sign_q    <= sign_d;
`endif
    end
  end

  assign bus.res_valid = res_vld_q;
  assign bus.result    = result_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_expr_eval.sv
module tb_expr_eval;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  expr_eval_if bus ();

  expr_eval dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        err;
    logic [15:0] res;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: each res_valid pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (clr_n && bus.res_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("result", {16'd0, bus.result}, {16'd0, e.res});
        check("err", {31'd0, bus.err}, {31'd0, e.err});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in = 8'h00;
    end
  endtask

  // streams s back-to-back; the '=' pushes the expected pulse
  task automatic send(input string s, input logic e_err, input logic [15:0] e_res);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in = s[i];
      if (s[i] == "=") begin
        exp_t e;
        e.err = e_err;
        e.res = e_res;
        e.cyc = cyc + 1;
        exp_q.push_back(e);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in = 8'h00;
    #1;
    check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rst_result", {16'd0, bus.result}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;

    send("3+4*5=", 1'b0, 16'd23);
    idle(3);
    check("result_hold", {16'd0, bus.result}, 32'd23);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);

    // gap between '*' and '4'
    send("2*3*", 1'b0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("gap_busy", {31'd0, bus.busy}, 32'd1);
    end
    send("4+1=", 1'b0, 16'd25);

    send("9*9*9*9*9*9=", 1'b0, 16'd7153);
    send("+3=", 1'b1, 16'd0);
    send("7=", 1'b0, 16'd7);
    send("=", 1'b1, 16'd0);
    send("1+=", 1'b1, 16'd0);
    send("12=", 1'b1, 16'd0);
    send("8*0+9*2=", 1'b0, 16'd18);
`ifdef EXPR_EVAL_SUB_EN
    send("5-7*2=", 1'b0, 16'hFFF7);
`else
    send("5-7*2=", 1'b1, 16'd0);
`endif

    // abort mid-expression with reset
    send("5+6", 1'b0, 16'd0);
    idle(1);
    check("pre_abort_busy", {31'd0, bus.busy}, 32'd1);
    clr_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_result", {16'd0, bus.result}, 32'd0);
    check("abort_err", {31'd0, bus.err}, 32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    send("8=", 1'b0, 16'd8);

    idle(5);
    check("pending_left", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/expr_eval.md
EXPR_EVAL -- requirements
Module: expr_eval

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port clr_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have the port in_valid, input, 1 bit: high means `in` carries a character this cycle.
REQ-004 The block SHALL have the port in, input, 8 bits: ASCII character from the upstream syntax-checking stage's input stream.
REQ-005 The block SHALL have the port res_valid, output, 1 bit: registered one-cycle pulse, result and err are valid.
REQ-006 The block SHALL have the port result, output, 16 bits: value of the completed expression, unsigned modulo 2^16.
REQ-007 The block SHALL have the port err, output, 1 bit: the completed expression was syntactically invalid; meaningful only while res_valid is high.
REQ-008 The block SHALL have the port busy, output, 1 bit: high while an expression is partially received (state is not IDLE).

Function
REQ-009 The block SHALL treat as tokens the digits '0'..'9' (48..57), '+' (43), '*' (42), and the terminator '=' (61); every other code SHALL be a syntax error.
REQ-010 The grammar SHALL be digit (op digit)* '=', with single-digit operands only.
REQ-011 The block SHALL sample characters only on cycles with in_valid=1; when in_valid=0, all state SHALL hold.
REQ-012 The FSM SHALL have exactly four states: IDLE (expect first digit), OPND (digit received, expect op or '='), OPER (op received, expect digit), ERR (absorb until '=').
REQ-013 Transitions SHALL be: IDLE--digit->OPND; OPND--op->OPER; OPER--digit->OPND; OPND--'='->IDLE with a result.
REQ-014 Any other token in IDLE, OPND or OPER SHALL go to ERR, including '=' in IDLE (empty expression) and '=' in OPER (trailing op).
REQ-015 In ERR, non-'=' characters SHALL be ignored; '=' SHALL go to IDLE with an error result.
REQ-016 Precedence SHALL be '*' over '+', evaluated left to right, using two 16-bit registers: sum and term.
REQ-017 On a digit d in IDLE, or in OPER after '+', the block SHALL set term=d.
REQ-018 On a digit d in OPER after '*', the block SHALL set term=term*d, truncated to 16 bits.
REQ-019 On '+', the block SHALL set sum=sum+term, mod 2^16.
REQ-020 On a valid '=', in the next cycle the block SHALL set result=sum+term (mod 2^16), err=0, res_valid=1.
REQ-021 On '=' reaching or within ERR, in the next cycle the block SHALL set result=0, err=1, res_valid=1.
REQ-022 Latency SHALL be exactly 1 cycle from the '=' sample edge to res_valid high; res_valid SHALL be high for exactly 1 cycle.
REQ-023 result and err SHALL hold their values until the next res_valid pulse.
REQ-024 On the same edge as '=', sum and term SHALL clear to 0, and a digit on the very next valid cycle SHALL start a new expression (back-to-back expressions, no gap needed).
REQ-025 busy SHALL be 0 in IDLE and 1 in OPND, OPER and ERR.

Reset
REQ-026 While clr_n=0, the block SHALL immediately force state=IDLE, sum=0, term=0, result=0, err=0, res_valid=0, busy=0.
REQ-027 Reset asserted mid-expression SHALL discard the partial expression with no res_valid pulse.
REQ-028 After clr_n deasserts, the first valid digit SHALL start a fresh expression.

Configuration
REQ-029 The macro EXPR_EVAL_SUB_EN SHALL control subtraction support.
REQ-030 With EXPR_EVAL_SUB_EN defined, '-' (45) SHALL be an operator of the same precedence as '+'.
REQ-031 With EXPR_EVAL_SUB_EN defined, the block SHALL track a 1-bit sign for the pending term, and on '+', '-' or '=' SHALL apply sum=sum+term or sum=sum-term per that sign, two's complement, mod 2^16.
REQ-032 Without EXPR_EVAL_SUB_EN, '-' SHALL be a syntax error, and no sign logic SHALL be present.

Verification
REQ-033 A bench SHALL cover: "3+4*5=" streamed back-to-back -> 1 cycle after '=', res_valid=1, result=23, err=0.
REQ-034 A bench SHALL cover: "2*3*4+1=" with in_valid low for 3 cycles between '*' and '4' -> result=25, err=0, busy=1 throughout the gap.
REQ-035 A bench SHALL cover: "9*9*9*9*9*9=" -> result=7153 (531441 mod 65536), err=0.
REQ-036 A bench SHALL cover: "+3=" then "7=" back-to-back -> first pulse err=1, result=0; second pulse err=0, result=7.
REQ-037 A bench SHALL cover: "5+6", clr_n low for 1 cycle, then "8=" -> no pulse for the aborted expression; single pulse with result=8.
REQ-038 With EXPR_EVAL_SUB_EN defined, a bench SHALL cover: "5-7*2=" -> result=16'hFFF7, err=0; without the macro, the same stimulus -> err=1, result=0.
